prisoner_seeker: RTL and testbench

PRISONER_SEEKER -- requirements
Module: prisoner_seeker

---
 rtl/prisoner_seeker.sv | 185 ++++++++++++++++++
 tb/tb_prisoner_seeker.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/prisoner_seeker.sv
// prisoner_seeker: follows the box chain that starts at the prisoner's own
// number, opening one box every two cycles, until it finds his number, reads
// an out-of-range value, or has used up its allowance of openings.
module prisoner_seeker #(
  parameter int unsigned N_BOXES   = 8,
  parameter int unsigned MAX_TRIES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] prisoner_id,
  input  logic       abort,
  input  logic [7:0] box_data,
  output logic       rd_enable,
  output logic [7:0] box_sel,
  output logic       busy,
  output logic       done,
  output logic       found,
  output logic       err,
  output logic [7:0] tries
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [7:0] MAX_TRIES_8 = MAX_TRIES[7:0];

  state_t     state_q, state_d;
  logic [7:0] id_q, id_d;
  logic [7:0] next_box_q, next_box_d;
  logic [7:0] tries_q, tries_d;
  logic       rd_enable_q, rd_enable_d;
  logic [7:0] box_sel_q, box_sel_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       found_q, found_d;
  logic       err_q, err_d;
  logic [7:0] tries_inc;

  // Opening counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A box index (or box content) that does not name a box in the room.
  function automatic logic out_of_range(input logic [7:0] v);
    return 32'(v) >= N_BOXES;
  endfunction

  assign tries_inc = sat_inc(tries_q);

  // Next-state and registered-output computation; the strobes (rd_enable,
  // box_sel, done) are produced one cycle ahead so they align with the state.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    next_box_d  = next_box_q;
    tries_d     = tries_q;
    busy_d      = busy_q;
    found_d     = found_q;
    err_d       = err_q;
    rd_enable_d = 1'b0;
    box_sel_d   = 8'd0;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // start beats a simultaneous abort: abort is only looked at when busy
        if (start) begin
          id_d       = prisoner_id;
          next_box_d = prisoner_id;
          tries_d    = 8'd0;
          found_d    = 1'b0;
          err_d      = 1'b0;
          if (out_of_range(prisoner_id)) begin
            // no box is ever touched for an impossible prisoner number
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            rd_enable_d = 1'b1;
            box_sel_d   = prisoner_id;
            busy_d      = 1'b1;
            state_d     = REQ;
          end
        end
      end

      REQ: begin
        if (abort) begin
          busy_d  = 1'b0;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = CHECK;
        end
      end

      CHECK: begin
        if (abort) begin
          // tries keeps the count of openings already completed
          busy_d  = 1'b0;
          found_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          tries_d = tries_inc;
          if (box_data == id_q) begin
            found_d = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end else if (out_of_range(box_data)) begin
            err_d   = 1'b1;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end else if (tries_inc == MAX_TRIES_8) begin
            found_d = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = FIN;
          end else begin
            next_box_d  = box_data;
            rd_enable_d = 1'b1;
            box_sel_d   = box_data;
            state_d     = REQ;
          end
        end
      end

      FIN: begin
        // done is already high this cycle; abort here cannot suppress it
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      id_q        <= 8'd0;
      next_box_q  <= 8'd0;
      tries_q     <= 8'd0;
      rd_enable_q <= 1'b0;
      box_sel_q   <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      found_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      next_box_q  <= next_box_d;
      tries_q     <= tries_d;
      rd_enable_q <= rd_enable_d;
      box_sel_q   <= box_sel_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      found_q     <= found_d;
      err_q       <= err_d;
    end
  end

  assign rd_enable = rd_enable_q;
  assign box_sel   = box_sel_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign found     = found_q;
  assign err       = err_q;
  assign tries     = tries_q;

endmodule

// File: tb/tb_prisoner_seeker.sv
// Bench for prisoner_seeker: a box memory answers read strobes, and a
// chain-walking reference model predicts which boxes get opened and the result.
module tb_prisoner_seeker;

  localparam int N_BOXES   = 8;
  localparam int MAX_TRIES = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] prisoner_id;
  logic       abort;
  logic [7:0] box_data;
  logic       rd_enable;
  logic [7:0] box_sel;
  logic       busy;
  logic       done;
  logic       found;
  logic       err;
  logic [7:0] tries;

  logic [7:0] mem [0:N_BOXES-1];
  logic [7:0] exp_boxes [$];

  int checks   = 0;
  int failures = 0;

  prisoner_seeker #(.N_BOXES(N_BOXES), .MAX_TRIES(MAX_TRIES)) dut (
    .clk(clk), .rst(rst), .start(start), .prisoner_id(prisoner_id),
    .abort(abort), .box_data(box_data), .rd_enable(rd_enable),
    .box_sel(box_sel), .busy(busy), .done(done), .found(found),
    .err(err), .tries(tries)
  );

  always #5 clk = ~clk;

  // Room contents appear on box_data in the cycle after a read strobe.
  always @(posedge clk) box_data <= rd_enable ? mem[box_sel[2:0]] : 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Walk the chain from the prisoner's own box by the rules of the game.
  function automatic void model(input logic [7:0] id, output int k, output bit f, output bit e);
    int nb;
    int v;
    exp_boxes.delete();
    k = 0; f = 0; e = 0;
    if (id >= N_BOXES) begin
      e = 1;
      return;
    end
    nb = id;
    forever begin
      exp_boxes.push_back(8'(nb));
      k++;
      v = mem[nb];
      if (v == id) begin f = 1; return; end
      if (v >= N_BOXES) begin e = 1; return; end
      if (k == MAX_TRIES) return;
      nb = v;
    end
  endfunction

  // Called at a negedge; launches a search and checks it to completion.
  task automatic run_search(input logic [7:0] id, input int inj_cyc, input bit abort_too);
    int k, c, first_rd;
    bit ef, ee, got_done;
    logic [7:0] seen [$];
    model(id, k, ef, ee);
    start = 1'b1; prisoner_id = id; abort = abort_too;
    @(negedge clk);
    start = 1'b0; abort = 1'b0; prisoner_id = 8'($urandom);
    c = 1; got_done = 0; first_rd = 0;
    while (c <= 600) begin
      start = (c == inj_cyc);
      if (start) prisoner_id = id ^ 8'd1;
      if (rd_enable) begin
        seen.push_back(box_sel);
        if (first_rd == 0) first_rd = c;
      end else begin
        chk("box_sel_idle_zero", box_sel, 0);
      end
      if (done) begin got_done = 1; break; end
      chk("busy_during_search", busy, 1);
      @(negedge clk);
      c++;
    end
    start = 1'b0;
    chk("done_seen", got_done, 1);
    if (got_done) begin
      chk("done_cycle", c, 2 * k + 1);
      chk("found", found, ef);
      chk("err", err, ee);
      chk("tries", tries, k);
      chk("busy_at_done", busy, 0);
      chk("reads_count", seen.size(), exp_boxes.size());
      if (k > 0) chk("first_read_cycle", first_rd, 1);
      for (int i = 0; i < seen.size() && i < exp_boxes.size(); i++)
        chk("read_box", seen[i], exp_boxes[i]);
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("found_held", found, ef);
      chk("tries_held", tries, k);
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < N_BOXES; i++) mem[i] = 8'(i);
  endtask

  initial begin
    int nd;
    rst = 1'b0; start = 1'b0; abort = 1'b0; prisoner_id = 8'd0;
    set_identity();
    #23;
    chk("rst_rd_enable", rd_enable, 0);
    chk("rst_box_sel", box_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_found", found, 0);
    chk("rst_err", err, 0);
    chk("rst_tries", tries, 0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);

    // identity room, own box holds own number
    run_search(8'd3, 0, 1'b0);

    // three-box cycle 0 -> 5 -> 2 -> 0
    set_identity(); mem[0] = 8'd5; mem[5] = 8'd2; mem[2] = 8'd0;
    run_search(8'd0, 0, 1'b0);

    // six-long loop exhausts MAX_TRIES
    for (int i = 0; i < N_BOXES; i++) mem[i] = 8'(i);
    for (int i = 0; i < 6; i++) mem[i] = 8'((i + 1) % 6);
    run_search(8'd0, 0, 1'b0);

    // corrupt box content
    set_identity(); mem[1] = 8'd9;
    run_search(8'd1, 0, 1'b0);

    // impossible prisoner number
    run_search(8'd9, 0, 1'b0);

    // start during a search is ignored
    set_identity(); mem[0] = 8'd5; mem[5] = 8'd2; mem[2] = 8'd0;
    run_search(8'd0, 2, 1'b0);

    // abort together with start in idle: start wins
    set_identity();
    run_search(8'd3, 0, 1'b1);

    // abort in the second CHECK cycle
    mem[0] = 8'd5; mem[5] = 8'd2; mem[2] = 8'd0;
    start = 1'b1; prisoner_id = 8'd0;
    @(negedge clk); start = 1'b0;          // cycle 1 (REQ)
    @(negedge clk);                         // cycle 2 (CHECK)
    @(negedge clk);                         // cycle 3 (REQ)
    @(negedge clk); abort = 1'b1;           // cycle 4 (CHECK)
    @(negedge clk); abort = 1'b0;           // cycle 5
    chk("abort_busy", busy, 0);
    chk("abort_rd_enable", rd_enable, 0);
    chk("abort_done", done, 0);
    chk("abort_found", found, 0);
    chk("abort_err", err, 0);
    chk("abort_tries_kept", tries, 1);
    nd = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) nd++;
      @(negedge clk);
    end
    chk("abort_no_done", nd, 0);

    // reset during a REQ cycle, then a fresh start right after release
    set_identity();
    start = 1'b1; prisoner_id = 8'd0;
    @(negedge clk); start = 1'b0;
    chk("pre_rst_rd_enable", rd_enable, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_rd_enable", rd_enable, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_box_sel", box_sel, 0);
    @(negedge clk); rst = 1'b1;
    run_search(8'd2, 0, 1'b0);

    // randomized rooms and prisoners, some values out of range
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N_BOXES; i++) mem[i] = 8'($urandom_range(0, 9));
      run_search(8'($urandom_range(0, 9)), 0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
